// File: rtl/decode_mul_arbiter.sv
// Round-robin arbiter that shares one pipelined signed multiplier among NUM_REQ
// requesters. A tag pipeline follows each product to its owner, and a one-entry
// holding register per requester returns the result.
module decode_mul_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned A_WIDTH     = 40,
    parameter int unsigned B_WIDTH     = 23,
    parameter int unsigned P_WIDTH     = 62,
    parameter int unsigned MUL_LATENCY = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*A_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*B_WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]         rsp_valid,
    input  logic [NUM_REQ-1:0]         rsp_ready,
    output logic [NUM_REQ*P_WIDTH-1:0] rsp_p,
    output logic                       mul_ce,
    output logic [A_WIDTH-1:0]         mul_din0,
    output logic [B_WIDTH-1:0]         mul_din1,
    input  logic [P_WIDTH-1:0]         mul_dout
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned Tail = MUL_LATENCY - 1;

    logic               tag_v_q   [MUL_LATENCY];
    logic [IdxW-1:0]    tag_idx_q [MUL_LATENCY];
    logic [NUM_REQ-1:0] hold_v_q;
    logic [P_WIDTH-1:0] hold_p_q  [NUM_REQ];
    logic [IdxW-1:0]    rr_ptr_q;

    logic            tail_v;
    logic [IdxW-1:0] tail_idx;
    logic            stall;
    logic            grant_fire;
    logic [IdxW-1:0] grant_idx;
    logic [IdxW-1:0] cand;

    // The tail tag is aligned with mul_dout; it stalls only when its owner's
    // holding register is full and not draining this cycle.
    assign tail_v   = tag_v_q[Tail];
    assign tail_idx = tag_idx_q[Tail];
    assign stall    = tail_v & hold_v_q[tail_idx] & ~rsp_ready[tail_idx];
    assign mul_ce   = ~stall & reset;

    // Round-robin search starting at rr_ptr, wrapping; first valid wins.
    always_comb begin
        grant_fire = 1'b0;
        grant_idx  = '0;
        cand       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = IdxW'((32'(rr_ptr_q) + k) % NUM_REQ);
            if (mul_ce && !grant_fire && req_valid[cand]) begin
                grant_fire = 1'b1;
                grant_idx  = cand;
            end
        end
    end

    // Grant one-hot and operand mux; operands read zero without a grant.
    always_comb begin
        req_ready = '0;
        mul_din0  = '0;
        mul_din1  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_fire && grant_idx == IdxW'(i)) begin
                req_ready[i] = 1'b1;
                mul_din0     = req_a[i*A_WIDTH +: A_WIDTH];
                mul_din1     = req_b[i*B_WIDTH +: B_WIDTH];
            end
        end
    end

    // Pack the holding registers onto the response bus.
    always_comb begin
        rsp_valid = hold_v_q;
        rsp_p     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            rsp_p[i*P_WIDTH +: P_WIDTH] = hold_p_q[i];
        end
    end

    // Tag pipeline, round-robin pointer and holding registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned s = 0; s < MUL_LATENCY; s++) begin
                tag_v_q[s]   <= 1'b0;
                tag_idx_q[s] <= '0;
            end
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                hold_p_q[i] <= '0;
            end
            hold_v_q <= '0;
            rr_ptr_q <= '0;
        end else begin
            if (mul_ce) begin
                tag_v_q[0]   <= grant_fire;
                tag_idx_q[0] <= grant_idx;
                for (int unsigned s = 1; s < MUL_LATENCY; s++) begin
                    tag_v_q[s]   <= tag_v_q[s-1];
                    tag_idx_q[s] <= tag_idx_q[s-1];
                end
            end
            if (grant_fire) begin
                rr_ptr_q <= (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
            end
            // A capture overrides a same-cycle drain of the same entry.
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (mul_ce && tail_v && tail_idx == IdxW'(i)) begin
                    hold_v_q[i] <= 1'b1;
                    hold_p_q[i] <= mul_dout;
                end else if (hold_v_q[i] && rsp_ready[i]) begin
                    hold_v_q[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_decode_mul_arbiter.sv
// Directed bench for decode_mul_arbiter: one instance at MUL_LATENCY=1 and one
// at MUL_LATENCY=3, each driving a behavioural clock-enabled multiplier.
module tb_decode_mul_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    // Latency-1 instance signals
    logic [3:0]   valid1 = '0, rdy1, rv1, rr1 = '0;
    logic [159:0] a1 = '0;
    logic [91:0]  b1 = '0;
    logic [247:0] p1;
    logic         ce1;
    logic [39:0]  d01;
    logic [22:0]  d11;
    logic [61:0]  dout1 = '0;

    // Latency-3 instance signals
    logic [3:0]   valid3 = '0, rdy3, rv3, rr3 = '0;
    logic [159:0] a3 = '0;
    logic [91:0]  b3 = '0;
    logic [247:0] p3;
    logic         ce3;
    logic [39:0]  d03;
    logic [22:0]  d13;
    logic [61:0]  m3_0 = '0, m3_1 = '0, dout3 = '0;

    decode_mul_arbiter #(.MUL_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .req_valid(valid1), .req_ready(rdy1),
        .req_a(a1), .req_b(b1), .rsp_valid(rv1), .rsp_ready(rr1), .rsp_p(p1),
        .mul_ce(ce1), .mul_din0(d01), .mul_din1(d11), .mul_dout(dout1)
    );

    decode_mul_arbiter #(.MUL_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset), .req_valid(valid3), .req_ready(rdy3),
        .req_a(a3), .req_b(b3), .rsp_valid(rv3), .rsp_ready(rr3), .rsp_p(p3),
        .mul_ce(ce3), .mul_din0(d03), .mul_din1(d13), .mul_dout(dout3)
    );

    // Behavioural multipliers: signed product modulo 2^62, clock-enabled stages.
    always @(posedge clk) begin
        if (ce1) dout1 <= 62'($signed(d01)) * 62'($signed(d11));
        if (ce3) begin
            m3_0  <= 62'($signed(d03)) * 62'($signed(d13));
            m3_1  <= m3_0;
            dout3 <= m3_1;
        end
    end

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  exp_rdy;
        logic [3:0]  exp_rv;
        logic [61:0] exp_p;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input logic [61:0] act, input logic [61:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set1(input int i, input logic [39:0] a, input logic [22:0] b);
        a1[i*40 +: 40] = a;
        b1[i*23 +: 23] = b;
    endtask

    task automatic set3(input int i, input logic [39:0] a, input logic [22:0] b);
        a3[i*40 +: 40] = a;
        b3[i*23 +: 23] = b;
    endtask

    function automatic logic [61:0] lane1(input int i);
        return p1[i*62 +: 62];
    endfunction

    function automatic logic [61:0] lane3(input int i);
        return p3[i*62 +: 62];
    endfunction

    initial begin
        int lane;
        // Round-robin table with ptr=0 and rsp_ready all ones.
        tbl[0]  = '{4'hF, 4'b0001, 4'b0000, 62'd0};
        tbl[1]  = '{4'hF, 4'b0010, 4'b0000, 62'd0};
        tbl[2]  = '{4'hF, 4'b0100, 4'b0001, -62'sd2};
        tbl[3]  = '{4'hF, 4'b1000, 4'b0010, -62'sd6};
        tbl[4]  = '{4'hF, 4'b0001, 4'b0100, -62'sd12};
        tbl[5]  = '{4'h0, 4'b0000, 4'b1000, -62'sd20};
        tbl[6]  = '{4'h0, 4'b0000, 4'b0001, -62'sd2};
        tbl[7]  = '{4'hA, 4'b0010, 4'b0000, 62'd0};
        tbl[8]  = '{4'hA, 4'b1000, 4'b0000, 62'd0};
        tbl[9]  = '{4'h0, 4'b0000, 4'b0010, -62'sd6};
        tbl[10] = '{4'h0, 4'b0000, 4'b1000, -62'sd20};

        // Reset state
        cyc();
        cyc();
        #1;
        chk("rst_ready", 62'(rdy1), 62'd0);
        chk("rst_rsp_valid", 62'(rv1), 62'd0);
        chk("rst_ce", 62'(ce1), 62'd0);
        chk("rst_din0", 62'(d01), 62'd0);
        chk("rst_din1", 62'(d11), 62'd0);
        chk("rst_rsp_p", 62'(|p1), 62'd0);
        chk("rst_ce_l3", 62'(ce3), 62'd0);

        // Single op: requester 0, 3 * -5
        cyc(); reset = 1'b1; valid1 = 4'b0001; set1(0, 40'sd3, -23'sd5); #1;
        chk("single_ce", 62'(ce1), 62'd1);
        chk("single_grant", 62'(rdy1), 62'b0001);
        chk("single_din0", 62'(d01), 62'd3);
        chk("single_din1", 62'(d11), 62'h7FFFFB);
        cyc(); valid1 = '0; #1;
        chk("single_t1_rv", 62'(rv1), 62'd0);
        cyc(); rr1 = 4'b0001; #1;
        chk("single_t2_rv", 62'(rv1), 62'b0001);
        chk("single_t2_p", lane1(0), -62'sd15);
        cyc(); rr1 = '0; #1;
        chk("single_drained", 62'(rv1), 62'd0);

        // Corner signs on requesters 1 and 2 (ptr=1)
        cyc(); rr1 = 4'hF; valid1 = 4'b0010; set1(1, 40'h80_0000_0000, 23'h400000); #1;
        chk("corner_g1", 62'(rdy1), 62'b0010);
        cyc(); valid1 = 4'b0100; set1(2, 40'h7F_FFFF_FFFF, 23'h400000); #1;
        chk("corner_g2", 62'(rdy1), 62'b0100);
        cyc(); valid1 = '0; #1;
        chk("corner_rv1", 62'(rv1), 62'b0010);
        chk("corner_p_pos", lane1(1), 62'h2000_0000_0000_0000);
        cyc(); #1;
        chk("corner_rv2", 62'(rv1), 62'b0100);
        chk("corner_p_neg", lane1(2), 62'h2000_0000_0040_0000);

        // Backpressure on requester 2 (ptr=3)
        cyc(); rr1 = 4'b1011; valid1 = 4'b0100; set1(2, 40'sd7, 23'sd6); #1;
        chk("bp_g1", 62'(rdy1), 62'b0100);
        cyc(); set1(2, -40'sd9, 23'sd11); #1;
        chk("bp_g2", 62'(rdy1), 62'b0100);
        chk("bp_g2_ce", 62'(ce1), 62'd1);
        cyc(); valid1 = 4'b0001; set1(0, 40'sd100, -23'sd1); #1;
        chk("bp_stall_ce", 62'(ce1), 62'd0);
        chk("bp_stall_rdy", 62'(rdy1), 62'd0);
        chk("bp_stall_rv", 62'(rv1), 62'b0100);
        chk("bp_stall_p", lane1(2), 62'd42);
        cyc(); #1;
        chk("bp_stall2_ce", 62'(ce1), 62'd0);
        chk("bp_stall2_rdy", 62'(rdy1), 62'd0);
        rr1 = 4'hF; #1;
        chk("bp_resume_ce", 62'(ce1), 62'd1);
        chk("bp_resume_rdy", 62'(rdy1), 62'b0001);
        cyc(); valid1 = '0; #1;
        chk("bp_second_rv", 62'(rv1), 62'b0100);
        chk("bp_second_p", lane1(2), -62'sd99);
        cyc(); #1;
        chk("bp_req0_rv", 62'(rv1), 62'b0001);
        chk("bp_req0_p", lane1(0), -62'sd100);

        // Reset mid-flight (ptr=1)
        cyc(); rr1 = '0; valid1 = 4'b0011; set1(0, 40'sd5, 23'sd5); set1(1, 40'sd6, 23'sd6); #1;
        chk("mid_g1", 62'(rdy1), 62'b0010);
        cyc(); valid1 = 4'b0001; #1;
        chk("mid_g0", 62'(rdy1), 62'b0001);
        cyc(); valid1 = '0; reset = 1'b0; #1;
        chk("mid_rst_ce", 62'(ce1), 62'd0);
        chk("mid_rst_rdy", 62'(rdy1), 62'd0);
        chk("mid_held_before_rst", 62'(rv1), 62'b0010);
        cyc(); reset = 1'b1; #1;
        chk("mid_after_rv_a", 62'(rv1), 62'd0);
        cyc(); #1;
        chk("mid_after_rv_b", 62'(rv1), 62'd0);

        // Round-robin table (ptr=0 after reset)
        rr1 = 4'hF;
        for (int i = 0; i < 4; i++) begin
            set1(i, 40'(i + 2), -23'(i + 1));
        end
        for (int k = 0; k < 11; k++) begin
            cyc(); valid1 = tbl[k].valid; #1;
            chk($sformatf("rr_rdy[%0d]", k), 62'(rdy1), 62'(tbl[k].exp_rdy));
            chk($sformatf("rr_rv[%0d]", k), 62'(rv1), 62'(tbl[k].exp_rv));
            chk($sformatf("rr_ce[%0d]", k), 62'(ce1), 62'd1);
            if (tbl[k].exp_rv != 4'd0) begin
                lane = 0;
                for (int j = 0; j < 4; j++) if (tbl[k].exp_rv[j]) lane = j;
                chk($sformatf("rr_p[%0d]", k), lane1(lane), tbl[k].exp_p);
            end
        end

        // Latency-3 instance: requesters 1 and 3 back to back, then 1 again
        cyc(); rr3 = 4'b1000; valid3 = 4'b1010;
        set3(1, -40'sd1234, 23'sd567); set3(3, 40'sd123456789, -23'sd1000); #1;
        chk("l3_g1", 62'(rdy3), 62'b0010);
        cyc(); valid3 = 4'b1000; #1;
        chk("l3_g3", 62'(rdy3), 62'b1000);
        cyc(); valid3 = 4'b0010; set3(1, 40'h80_0000_0000, 23'h3FFFFF); #1;
        chk("l3_g1b", 62'(rdy3), 62'b0010);
        cyc(); valid3 = '0; #1;
        chk("l3_t3_rv", 62'(rv3), 62'd0);
        cyc(); #1;
        chk("l3_t4_rv", 62'(rv3), 62'b0010);
        chk("l3_t4_p1", lane3(1), -62'sd699678);
        chk("l3_t4_ce", 62'(ce3), 62'd1);
        cyc(); rr3 = 4'b1010; #1;
        chk("l3_t5_rv", 62'(rv3), 62'b1010);
        chk("l3_t5_p3", lane3(3), -62'sd123456789000);
        chk("l3_t5_ce", 62'(ce3), 62'd1);
        cyc(); #1;
        chk("l3_capture_wins_rv", 62'(rv3), 62'b0010);
        chk("l3_capture_wins_p", lane3(1), 62'h2000_0080_0000_0000);
        cyc(); rr3 = '0; #1;
        chk("l3_drained", 62'(rv3), 62'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
